// File: rtl/cpu_pkg.sv
// Shared core definitions for the fetch stage: reset PC, branch-counter
// encodings and the saturating counter helpers used by the BTB.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t ALLOC_CTR = WT;
  localparam ctr_t RESET_CTR = WNT;

  function automatic ctr_t sat_inc(input ctr_t c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      default: sat_inc = ST;
    endcase
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    case (c)
      ST:      sat_dec = WT;
      WT:      sat_dec = WNT;
      default: sat_dec = SNT;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control/feedback bundle between the fetch stage and its surroundings
// (run/hazard control, EX redirect and BTB update, fetch PC outputs).
interface fetch_stage_if;
  logic        run;
  logic        bubble;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc_out;
  logic        predict_taken;

  modport master (
    output run, bubble, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc_out, predict_taken
  );

  modport slave (
    input  run, bubble, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc_out, predict_taken
  );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational lookup port, synchronous update port.
module btb
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             lk_hit;
  logic             up_hit;
  logic             unused_lsbs;

  // Instructions are word aligned, so the byte-offset bits take no part.
  assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = target_q[lk_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= RESET_CTR;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_q[up_idx]    <= sat_inc(ctr_q[up_idx]);
          target_q[up_idx] <= upd_target;
        end else begin
          ctr_q[up_idx]    <= sat_dec(ctr_q[up_idx]);
        end
      end else if (upd_taken) begin
        // A taken miss replaces whatever lived at this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= ALLOC_CTR;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC register, next-PC selection
// (redirect > bubble hold > BTB prediction > PC+4) and the BTB.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.slave    bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        pred_taken;
  logic [31:0] pred_target;

  btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (bus.run && bus.upd_valid),
    .upd_pc      (bus.upd_pc),
    .upd_target  (bus.upd_target),
    .upd_taken   (bus.upd_taken)
  );

  always_comb begin
    pc_next = pc_q + 32'(INSTR_BYTES);
    if (bus.redirect)    pc_next = bus.redirect_pc;
    else if (bus.bubble) pc_next = pc_q;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc_q <= RESET_PC;
    else if (bus.run) pc_q <= pc_next;
  end

  assign bus.pc_out        = pc_q;
  assign bus.predict_taken = pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential PC, hazards, redirects,
// BTB allocation/aliasing/saturation, run freeze, async reset and wrap.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   passed;
  int   failed;
  int   total;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_pt);
    chk({tag, ".pc"}, bus.pc_out, exp_pc);
    chk({tag, ".pt"}, {31'b0, bus.predict_taken}, {31'b0, exp_pt});
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect    = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] target, input logic taken);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = target;
    bus.upd_taken  = taken;
    step();
    bus.upd_valid  = 1'b0;
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst_n = 1'b0;
    bus.run = 1'b0; bus.bubble = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;

    #12;
    chk_pc("reset", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = 1'b1;

    // Sequential fetch with a two-cycle bubble at 0x8.
    step(); chk_pc("seq4", 32'h4, 1'b0);
    step(); chk_pc("seq8", 32'h8, 1'b0);
    bus.bubble = 1'b1;
    step(); chk_pc("bub1", 32'h8, 1'b0);
    step(); chk_pc("bub2", 32'h8, 1'b0);
    bus.bubble = 1'b0;
    step(); chk_pc("seqC", 32'hC, 1'b0);
    step(); chk_pc("seq10", 32'h10, 1'b0);

    // Redirect wins over bubble.
    bus.bubble = 1'b1;
    goto(32'h100);
    bus.bubble = 1'b0;
    chk_pc("redir_bub", 32'h100, 1'b0);

    // Allocate 0x10 -> 0x40 (ctr WT), then fetch follows the prediction.
    upd(32'h10, 32'h40, 1'b1);
    goto(32'h10);
    chk_pc("alloc_hit", 32'h10, 1'b1);
    step(); chk_pc("pred_tgt", 32'h40, 1'b0);

    // Three not-taken: WT -> WNT -> SNT -> SNT (floor).
    upd(32'h10, 32'h40, 1'b0);
    upd(32'h10, 32'h40, 1'b0);
    goto(32'h10);
    chk_pc("dec2", 32'h10, 1'b0);
    step(); chk_pc("dec2_seq", 32'h14, 1'b0);
    upd(32'h10, 32'h40, 1'b0);
    upd(32'h10, 32'h40, 1'b1);
    goto(32'h10);
    chk_pc("floor_inc1", 32'h10, 1'b0);
    upd(32'h10, 32'h40, 1'b1);
    goto(32'h10);
    chk_pc("floor_inc2", 32'h10, 1'b1);

    // Aliasing: 0x50 shares index 4 with 0x10, replaces it.
    upd(32'h50, 32'h80, 1'b1);
    goto(32'h10);
    chk_pc("alias_old", 32'h10, 1'b0);
    goto(32'h50);
    chk_pc("alias_new", 32'h50, 1'b1);
    upd(32'h90, 32'hC0, 1'b0);
    goto(32'h50);
    chk_pc("miss_nt", 32'h50, 1'b1);

    // run=0 freezes PC and BTB despite redirect and update requests.
    bus.run = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h50; bus.upd_target = 32'h300; bus.upd_taken = 1'b0;
    step(); chk_pc("frz1", 32'h50, 1'b1);
    step(); chk_pc("frz2", 32'h50, 1'b1);
    step(); chk_pc("frz3", 32'h50, 1'b1);
    bus.redirect = 1'b0; bus.upd_valid = 1'b0;
    bus.run = 1'b1;
    step(); chk_pc("frz_tgt", 32'h80, 1'b0);

    // Asynchronous reset mid-run clears PC and BTB.
    goto(32'h50);
    #2 rst_n = 1'b0;
    #1 chk_pc("async_rst", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    goto(32'h50);
    chk_pc("rst_btb", 32'h50, 1'b0);

    // PC wraps at the top of the address space.
    goto(32'hFFFF_FFFC);
    chk_pc("wrap_pre", 32'hFFFF_FFFC, 1'b0);
    step(); chk_pc("wrap", 32'h0, 1'b0);

    // Saturation: WT -> ST -> ST -> ST, one not-taken leaves WT.
    upd(32'h20, 32'h60, 1'b1);
    upd(32'h20, 32'h60, 1'b1);
    upd(32'h20, 32'h60, 1'b1);
    upd(32'h20, 32'h60, 1'b1);
    upd(32'h20, 32'h60, 1'b0);
    goto(32'h20);
    chk_pc("sat", 32'h20, 1'b1);
    step(); chk_pc("sat_tgt", 32'h60, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core; drives the PC to instruction memory and the PC/prediction-bit inputs of the IF/ID register.
- Holds the architectural fetch PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Selects next PC from: EX-stage mispredict redirect, hazard hold, BTB-predicted target, or PC+4.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 4.
- IDX_W, log2(BTB_ENTRIES), index width; derived, not overridden.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  global run enable; 0 freezes all state.
- bubble  in  1  load-use hazard stall from ID; holds PC.
- redirect  in  1  EX reports misprediction; forces PC to redirect_pc.
- redirect_pc  in  32  correct next PC from EX.
- upd_valid  in  1  EX resolved a branch/jump this cycle; update BTB.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  resolved taken-target of that branch.
- upd_taken  in  1  actual outcome: 1 taken, 0 not taken.
- pc_out  out  32  current fetch PC; to IMEM address and IF/ID PC input.
- predict_taken  out  1  BTB prediction for pc_out; to IF/ID prediction-bit input.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, all BTB valid bits=0, all counters=2'b01. pc_out=RESET_PC, predict_taken=0 immediately. Reset mid-operation discards any pending update.
- BTB fields per entry: valid, tag=pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index=pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup is combinational on PC: hit = valid & tag match. predict_taken = hit & ctr[1]. pred_target = entry target.
- Next-PC priority, applied only at a rising edge with run=1:
  - redirect=1 → PC=redirect_pc. Overrides bubble.
  - else bubble=1 → PC holds.
  - else predict_taken=1 → PC=pred_target.
  - else → PC=PC+4. Wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- run=0: PC and BTB hold. Redirect and update inputs are ignored, so EX must hold them while run=0.
- BTB update at the edge, when run=1 and upd_valid=1, indexed by upd_pc:
  - Tag hit, upd_taken=1: ctr=sat_inc(ctr), capped at 2'b11; target=upd_target.
  - Tag hit, upd_taken=0: ctr=sat_dec(ctr), floored at 2'b00; target unchanged; entry stays valid.
  - Miss, upd_taken=1: allocate (overwrite) with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, upd_taken=0: no change.
- Update is independent of bubble/redirect; it still occurs when the PC holds.
- Same-cycle lookup and update at the same index: lookup and predict_taken use pre-edge contents. New contents are visible the cycle after the edge.
- Latency: PC selection takes 1 cycle. No internal pipelining. Lookup and prediction are zero-cycle combinational from PC.

Decomposition:
- Shared package (cpu_pkg): RESET_PC default, counter encodings (SNT=00, WNT=01, WT=10, ST=11), ALLOC_CTR=WT, INSTR_BYTES=4.
- One sub-module, btb:
  - Storage array, combinational lookup port, synchronous update port with saturating counter logic.
- fetch_stage keeps the PC register and next-PC mux.

Test Plan:
- Reset then 4 edges with run=1, no branches → pc_out 0,4,8,C,10; predict_taken=0 throughout.
- bubble=1 for 2 cycles at PC=8 → pc_out stays 8 for 2 cycles, then 0xC. With redirect=1, redirect_pc=0x100 and bubble=1 in the same cycle → pc_out=0x100 next cycle.
- upd_valid, upd_pc=0x10, upd_target=0x40, upd_taken=1, then fetch reaches 0x10 → predict_taken=1, next pc_out=0x40. Two not-taken updates for 0x10 → predict_taken=0 (ctr 10→01→00), fetch proceeds to 0x14.
- Aliasing with 16 entries: allocate 0x10→0x40, then taken update for 0x50 (same index, tag differs) → fetch at 0x10 predict_taken=0. One not-taken update at a miss address → entry unchanged.
- run=0 for 3 cycles with redirect=1 and upd_valid=1 asserted → PC and BTB unchanged. rst_n pulsed low mid-run → pc_out=0 asynchronously, prior BTB entries gone.
- PC=32'hFFFF_FFFC, no hit → next pc_out=0. Saturation check: 4 taken updates → ctr 11; 1 not-taken → still predicts taken.
